// File: rtl/ysyx_23060020_rf_mp.sv
// ysyx_23060020_rf_mp: multi-port integer register file with optional
// write-to-read bypass, a per-register pending scoreboard and a sequential
// clear engine that zeroes storage after reset and on request.
module ysyx_23060020_rf_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_req,
    output logic                clear_busy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rd_pending
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pending_q, pending_d;

    logic [NWR-1:0]  wr_act;
    logic            alloc_act;

    // Qualify write ports and alloc: only in IDLE, and never to r0 when hardwired.
    always_comb begin
        wr_act = '0;
        for (int unsigned i = 0; i < NWR; i++) begin
            wr_act[i] = (state_q == IDLE) && wen[i] &&
                        !(ZERO_REG && (waddr[i*AW +: AW] == '0));
        end
        alloc_act = (state_q == IDLE) && alloc_en &&
                    !(ZERO_REG && (alloc_addr == '0));
    end

    // FSM state and clear pointer register; pending is reset with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            ptr_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
        end
    end

    // FSM next state: walk the pointer through every register, then idle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // FSM outputs: the file is unusable while clearing.
    always_comb begin
        clear_busy = (state_q == CLEAR);
    end

    // Storage next value: clear one entry per cycle, otherwise apply writes
    // in ascending port order so the highest port wins on a conflict.
    always_comb begin
        regs_d = regs_q;
        if (state_q == CLEAR) begin
            regs_d[ptr_q] = '0;
        end else begin
            for (int unsigned i = 0; i < NWR; i++) begin
                if (wr_act[i]) begin
                    regs_d[waddr[i*AW +: AW]] = wdata[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Storage has no reset; the clear engine zeroes it after reset.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Scoreboard next value: a clear request wipes it, otherwise writes
    // retire entries and alloc (applied last) marks one pending.
    always_comb begin
        pending_d = pending_q;
        if (state_q == IDLE) begin
            if (clear_req) begin
                pending_d = '0;
            end else begin
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (wr_act[i]) begin
                        pending_d[waddr[i*AW +: AW]] = 1'b0;
                    end
                end
                if (alloc_act) begin
                    pending_d[alloc_addr] = 1'b1;
                end
            end
        end
    end

    // Combinational read ports with optional bypass from same-cycle writes.
    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] val;
        logic            pend;
        logic            hit;
        rdata      = '0;
        rd_pending = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            ra   = raddr[j*AW +: AW];
            val  = regs_q[ra];
            pend = pending_q[ra];
            hit  = 1'b0;
            if (BYPASS) begin
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (wr_act[i] && (waddr[i*AW +: AW] == ra)) begin
                        hit = 1'b1;
                        val = wdata[i*XLEN +: XLEN];
                    end
                end
            end
            if (hit) begin
                pend = 1'b0;
            end
            if (ZERO_REG && (ra == '0)) begin
                val  = '0;
                pend = 1'b0;
            end
            if (state_q == CLEAR) begin
                val  = '0;
                pend = 1'b0;
            end
            rdata[j*XLEN +: XLEN] = val;
            rd_pending[j]         = pend;
        end
    end

endmodule

// File: tb/tb_ysyx_23060020_rf_mp.sv
// Directed bench for ysyx_23060020_rf_mp: one instance with bypass and one
// without, driven by the same stimulus and checked against hand values.
module tb_ysyx_23060020_rf_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_req;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic [9:0]  raddr;

    logic        clear_busy, clear_busy_nb;
    logic [63:0] rdata, rdata_nb;
    logic [1:0]  rd_pending, rd_pending_nb;

    int total = 0;
    int bad   = 0;
    int n;

    ysyx_23060020_rf_mp #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .clear_busy(clear_busy),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .raddr(raddr), .rdata(rdata), .rd_pending(rd_pending)
    );

    ysyx_23060020_rf_mp #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .clear_busy(clear_busy_nb),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .raddr(raddr), .rdata(rdata_nb), .rd_pending(rd_pending_nb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        wen = '0; waddr = '0; wdata = '0;
        alloc_en = 1'b0; alloc_addr = '0; clear_req = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wen[p] = 1'b1;
        waddr[p*5 +: 5] = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        raddr[p*5 +: 5] = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until clear_busy drops, bounded so a stuck engine cannot hang.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (clear_busy && cnt < 200) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        raddr = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(clear_busy), 32'd1);
        chk("rst_rdata0", rdata[31:0], 32'd0);
        chk("rst_pend", 32'(rd_pending), 32'd0);
        rst_n = 1'b1;
        count_busy(n);
        chk("rst_clear_len", n, 32'd32);
        chk("rst_clear_len_nb", 32'(clear_busy_nb), 32'd0);
        rd(0, 5); #1;
        chk("r5_zero", rdata[31:0], 32'd0);
        chk("r5_pend", 32'(rd_pending[0]), 32'd0);

        // Write/read with and without bypass
        wr(0, 3, 32'hDEADBEEF); rd(0, 3); #1;
        chk("byp_same", rdata[31:0], 32'hDEADBEEF);
        chk("nobyp_same", rdata_nb[31:0], 32'd0);
        step(); idle_in(); #1;
        chk("r3_next", rdata[31:0], 32'hDEADBEEF);
        chk("r3_next_nb", rdata_nb[31:0], 32'hDEADBEEF);

        // Write port conflict: highest port wins
        wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(1, 7); #1;
        chk("conf_byp", rdata[63:32], 32'h22);
        step(); idle_in(); #1;
        chk("conf_r7", rdata[63:32], 32'h22);
        chk("conf_r7_nb", rdata_nb[63:32], 32'h22);

        // Register 0 stays zero
        wr(0, 0, 32'h55); rd(0, 0); #1;
        chk("x0_same", rdata[31:0], 32'd0);
        step(); idle_in(); #1;
        chk("x0_next", rdata[31:0], 32'd0);

        // Scoreboard: alloc then retire
        alloc_en = 1'b1; alloc_addr = 5'd9; rd(0, 9); #1;
        chk("alloc_same", 32'(rd_pending[0]), 32'd0);
        step(); idle_in(); #1;
        chk("alloc_next", 32'(rd_pending[0]), 32'd1);
        wr(1, 9, 32'h99); #1;
        chk("retire_byp_pend", 32'(rd_pending[0]), 32'd0);
        chk("retire_byp_data", rdata[31:0], 32'h99);
        chk("retire_nb_pend", 32'(rd_pending_nb[0]), 32'd1);
        chk("retire_nb_data", rdata_nb[31:0], 32'd0);
        step(); idle_in(); #1;
        chk("retire_pend", 32'(rd_pending[0]), 32'd0);
        chk("retire_nb_after", 32'(rd_pending_nb[0]), 32'd0);
        chk("retire_data", rdata_nb[31:0], 32'h99);

        // Alloc and write same register in one cycle: alloc wins
        alloc_en = 1'b1; alloc_addr = 5'd4; wr(0, 4, 32'h44); rd(1, 4);
        step(); idle_in(); #1;
        chk("alloc_wr_pend", 32'(rd_pending[1]), 32'd1);
        chk("alloc_wr_data", rdata[63:32], 32'h44);

        // Alloc on r0 is dropped
        alloc_en = 1'b1; alloc_addr = 5'd0; rd(0, 0);
        step(); idle_in(); #1;
        chk("alloc_x0", 32'(rd_pending[0]), 32'd0);

        // Fill r1..r31 with their index
        for (int i = 1; i < 32; i++) begin
            wr(0, 5'(i), 32'(i));
            step();
        end
        idle_in();
        alloc_en = 1'b1; alloc_addr = 5'd6;
        step(); idle_in();
        rd(0, 31); rd(1, 6); #1;
        chk("fill_r31", rdata[31:0], 32'd31);
        chk("fill_r6", rdata[63:32], 32'd6);
        chk("fill_r6_pend", 32'(rd_pending[1]), 32'd1);

        // Clear request with a concurrent write, then writes during clear
        clear_req = 1'b1; wr(0, 2, 32'hAA);
        step(); idle_in();
        chk("clr_busy", 32'(clear_busy), 32'd1);
        chk("clr_rdata", rdata[31:0], 32'd0);
        chk("clr_pend", 32'(rd_pending[1]), 32'd0);
        n = 0;
        while (clear_busy && n < 200) begin
            wr(0, 5'd17, 32'hBAD0); wr(1, 5'd31, 32'hBAD1);
            alloc_en = 1'b1; alloc_addr = 5'd12;
            step();
            n++;
        end
        idle_in();
        chk("clr_len", n, 32'd32);
        for (int i = 0; i < 32; i++) begin
            rd(0, 5'(i)); #1;
            chk("clr_zero", rdata[31:0], 32'd0);
        end
        rd(0, 12); rd(1, 6); #1;
        chk("clr_pend_r12", 32'(rd_pending[0]), 32'd0);
        chk("clr_pend_r6", 32'(rd_pending[1]), 32'd0);

        // Reset mid-clear restarts the engine
        wr(0, 12, 32'h1234);
        step(); idle_in(); rd(0, 12); #1;
        chk("mid_r12", rdata[31:0], 32'h1234);
        clear_req = 1'b1;
        step(); idle_in();
        repeat (10) step();
        chk("mid_busy", 32'(clear_busy), 32'd1);
        rst_n = 1'b0; #1;
        chk("mid_rst_busy", 32'(clear_busy), 32'd1);
        repeat (2) step();
        rst_n = 1'b1;
        count_busy(n);
        chk("mid_clear_len", n, 32'd32);
        chk("mid_nb_idle", 32'(clear_busy_nb), 32'd0);
        rd(0, 12); #1;
        chk("mid_r12_zero", rdata[31:0], 32'd0);
        chk("mid_r12_zero_nb", rdata_nb[31:0], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
